row_line_buffer: RTL and testbench



---
 rtl/row_line_buffer_if.sv | 21 ++
 rtl/row_line_buffer.sv | 104 ++++++++++
 tb/tb_row_line_buffer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/row_line_buffer_if.sv
// Pixel-side access bus for one row buffer: single read/write port plus sweep status.
interface row_line_buffer_if #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 11
);
    logic                  wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;
    logic [DATA_WIDTH-1:0] douta;
    logic                  init_busy;

    modport master (
        output wea, addra, dina,
        input  douta, init_busy
    );

    modport slave (
        input  wea, addra, dina,
        output douta, init_busy
    );
endinterface

// File: rtl/row_line_buffer.sv
// One video row of RGB pixels in single-port write-first block RAM, zero-filled after every reset.
module row_line_buffer #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 2048,
    parameter int OUT_REG    = 0
) (
    input  logic            clka,
    input  logic            n_rst,
    row_line_buffer_if.slave mem_if
);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [0:0]            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_reg;
    logic                  in_range;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign in_range = ({1'b0, mem_if.addra} < DEPTH_EXT);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mem_we     = 1'b0;
        mem_addr   = mem_if.addra;
        mem_wdata  = mem_if.dina;
        case (state_reg)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_reg;
                mem_wdata = '0;
                cnt_next  = cnt_reg + 1'b1;
                if (cnt_reg == LAST_ADDR) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                mem_we = mem_if.wea & in_range;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
        // The array itself must stay untouched while reset is held.
        if (!n_rst) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clka or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clka) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Write-first read port; output forced to zero during the sweep and for unmapped addresses.
    always_ff @(posedge clka or negedge n_rst) begin
        if (!n_rst) begin
            rd_reg <= '0;
        end else if (state_reg == ST_INIT || !in_range) begin
            rd_reg <= '0;
        end else if (mem_if.wea) begin
            rd_reg <= mem_if.dina;
        end else begin
            rd_reg <= mem[mem_if.addra];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_reg;
            always_ff @(posedge clka or negedge n_rst) begin
                if (!n_rst) begin
                    out_reg <= '0;
                end else begin
                    out_reg <= rd_reg;
                end
            end
            assign mem_if.douta = out_reg;
        end else begin : g_no_out_reg
            assign mem_if.douta = rd_reg;
        end
    endgenerate

    assign mem_if.init_busy = (state_reg == ST_INIT);
endmodule

// File: tb/tb_row_line_buffer.sv
// Four row buffers (three latency-1, one latency-2) checked every cycle against a behavioural row model.
module tb_row_line_buffer;
    localparam int DW    = 24;
    localparam int AW    = 11;
    localparam int DEPTH = 2048;
    localparam int N     = 4;

    logic clka  = 1'b0;
    logic n_rst = 1'b1;
    always #5 clka = ~clka;

    logic          wea_t  [N];
    logic [AW-1:0] addr_t [N];
    logic [DW-1:0] din_t  [N];
    logic [DW-1:0] dout_t [N];
    logic          busy_t [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            row_line_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();
            assign bus_if.wea   = wea_t[gi];
            assign bus_if.addra = addr_t[gi];
            assign bus_if.dina  = din_t[gi];
            assign dout_t[gi]   = bus_if.douta;
            assign busy_t[gi]   = bus_if.init_busy;
            row_line_buffer #(
                .DATA_WIDTH(DW),
                .ADDR_WIDTH(AW),
                .DEPTH     (DEPTH),
                .OUT_REG   ((gi == N - 1) ? 1 : 0)
            ) u_dut (
                .clka  (clka),
                .n_rst (n_rst),
                .mem_if(bus_if)
            );
        end
    endgenerate

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: row contents, remaining sweep cycles, last two produced read words.
    logic [DW-1:0] mem_m  [N][DEPTH];
    int            sweep_m[N];
    logic [DW-1:0] h0     [N];
    logic [DW-1:0] h1     [N];

    always @(posedge clka or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < N; i++) begin
                sweep_m[i] = DEPTH;
                h0[i] = '0;
                h1[i] = '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                logic [DW-1:0] nv;
                if (sweep_m[i] > 0) begin
                    mem_m[i][DEPTH - sweep_m[i]] = '0;
                    sweep_m[i] = sweep_m[i] - 1;
                    nv = '0;
                end else if (wea_t[i]) begin
                    mem_m[i][addr_t[i]] = din_t[i];
                    nv = din_t[i];
                end else begin
                    nv = mem_m[i][addr_t[i]];
                end
                h1[i] = h0[i];
                h0[i] = nv;
            end
        end
    end

    always @(negedge clka) begin
        for (int i = 0; i < N; i++) begin
            check($sformatf("douta[%0d]", i), 32'(dout_t[i]), 32'((i == N - 1) ? h1[i] : h0[i]));
            check($sformatf("init_busy[%0d]", i), 32'(busy_t[i]), 32'(sweep_m[i] > 0));
        end
    end

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic drive(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wea_t[i]  = w;
        addr_t[i] = a;
        din_t[i]  = d;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) drive(i, 1'b0, '0, '0);
    endtask

    task automatic wait_init(output int cyc);
        cyc = 0;
        while (busy_t[0] && cyc < 5000) begin
            step();
            cyc++;
        end
    endtask

    function automatic logic [DW-1:0] row_pat(input int i);
        logic [AW-1:0] iv;
        iv = AW'(i);
        return {iv[7:0], ~iv[7:0], 8'h5A};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        idle_all();
        #1 n_rst = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("reset_douta", 32'(dout_t[0]), 32'h0);
        check("reset_busy", 32'(busy_t[0]), 32'h1);

        // Release, attempt a write during the sweep, measure sweep length.
        n_rst = 1'b1;
        drive(0, 1'b1, 11'd5, 24'hABCDEF);
        step(); step(); step();
        idle_all();
        wait_init(cyc);
        check("init_len", 32'(cyc + 3), 32'd2048);
        drive(0, 1'b0, 11'd5, '0);
        step();
        check("sweep_write_ignored", 32'(dout_t[0]), 32'h0);

        // Write-first and read latency.
        drive(0, 1'b1, 11'd10, 24'h123456);
        step();
        check("write_first", 32'(dout_t[0]), 32'h123456);
        drive(0, 1'b1, 11'd11, 24'h00FF00);
        step();
        check("write_first_11", 32'(dout_t[0]), 32'h00FF00);
        drive(0, 1'b0, 11'd10, '0);
        step();
        check("read_after_write", 32'(dout_t[0]), 32'h123456);

        // Full row fill, then reverse read-back on every instance.
        for (int a = 0; a < DEPTH; a++) begin
            for (int i = 0; i < N; i++) drive(i, 1'b1, AW'(a), row_pat(a));
            step();
        end
        for (int a = DEPTH - 1; a >= 0; a--) begin
            for (int i = 0; i < N; i++) drive(i, 1'b0, AW'(a), '0);
            step();
        end
        for (int i = 0; i < N; i++) drive(i, 1'b0, 11'h137, '0);
        step();
        check("row_pat_137", 32'(dout_t[0]), 32'h37C85A);
        step();
        check("row_pat_137_lat2", 32'(dout_t[3]), 32'h37C85A);

        // Randomised mixed traffic, concentrated on a small address window to force hits.
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N; i++) begin
                drive(i, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31)),
                      DW'($urandom));
            end
            step();
        end

        // Three-row rotation: distinct constants at identical addresses.
        for (int a = 0; a < 16; a++) begin
            drive(0, 1'b1, AW'(a), 24'h111111);
            drive(1, 1'b1, AW'(a), 24'h222222);
            drive(2, 1'b1, AW'(a), 24'h333333);
            drive(3, 1'b0, '0, '0);
            step();
        end
        for (int a = 0; a < 16; a++) begin
            for (int i = 0; i < 3; i++) drive(i, 1'b0, AW'(a), '0);
            step();
        end
        check("rot_r0", 32'(dout_t[0]), 32'h111111);
        check("rot_r1", 32'(dout_t[1]), 32'h222222);
        check("rot_r2", 32'(dout_t[2]), 32'h333333);

        // Asynchronous reset mid-operation.
        for (int i = 0; i < N; i++) drive(i, 1'b1, 11'd20, 24'hFFFFFF);
        step();
        for (int i = 0; i < N; i++) drive(i, 1'b0, 11'd20, '0);
        step();
        check("pre_reset_ffffff", 32'(dout_t[0]), 32'hFFFFFF);
        check("pre_reset_ffffff_lat2", 32'(dout_t[3]), 32'hFFFFFF);
        @(posedge clka);
        #2 n_rst = 1'b0;
        #1;
        for (int i = 0; i < N; i++) check($sformatf("async_clear[%0d]", i), 32'(dout_t[i]), 32'h0);
        step(); step();
        idle_all();
        n_rst = 1'b1;
        for (int k = 0; k < 100; k++) step();
        n_rst = 1'b0;
        step(); step();
        n_rst = 1'b1;
        wait_init(cyc);
        check("resweep_len", 32'(cyc), 32'd2048);
        drive(0, 1'b0, 11'd10, '0);
        step();
        check("after_resweep_addr10", 32'(dout_t[0]), 32'h0);

        // Two-stage output: write, flush to zero, then read.
        drive(3, 1'b1, 11'd3, 24'hC0FFEE);
        step();
        drive(3, 1'b0, 11'd4, '0);
        step(); step(); step();
        check("outreg_flushed", 32'(dout_t[3]), 32'h0);
        drive(3, 1'b0, 11'd3, '0);
        step();
        check("outreg_intervening", 32'(dout_t[3]), 32'h0);
        step();
        check("outreg_lat2", 32'(dout_t[3]), 32'hC0FFEE);

        idle_all();
        step(); step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
